sram_arbiter_2to1: RTL
======================

Name: sram_arbiter_2to1

Overview:
- Shares one synchronous single-port SRAM between the CPU instruction-fetch port and data-access port. Each requester side uses a req / addr_ok / data_ok handshake.
- Sits between the pipelined core and the unified memory macro, replacing the separate inst_sram / data_sram hookups.
- Keeps at most one transaction outstanding on the memory port.
- Data side has fixed priority; inst side is protected by an anti-starvation counter.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide.
- RD_LATENCY, 1, cycles from mem_en to valid mem_rdata (>=1).
- STARVE_MAX, 4, consecutive lost arbitrations after which a waiting inst request wins (>=1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request, held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  DATA_W/8  byte write enables for a store
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  DATA_W  load data
- mem_en  out  1  SRAM access enable
- mem_we  out  DATA_W/8  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid RD_LATENCY cycles after mem_en

Behaviour:
- Clocking and reset: single clock clk; resetn is synchronous and active-low. Reset is sampled on the clk edge only.
- Reset values:
  - state = IDLE, owner = none, latency counter = 0, starve counter = 0.
  - All *_addr_ok, *_data_ok and mem_en are 0; mem_we = 0.
  - inst_rdata and data_rdata = 0.
- FSM states:
  - IDLE: no access in flight.
  - BUSY: one access in flight. Owner is registered (INST/DATA); counter cnt counts RD_LATENCY..1.
- Grant opportunity: a cycle where state==IDLE, or state==BUSY with cnt==1 (back-to-back issue).
- Arbitration, in each grant opportunity with at least one req high:
  - Only data_req: grant DATA.
  - Only inst_req: grant INST.
  - Both: grant DATA unless starve counter == STARVE_MAX, in which case grant INST.
- Grant is combinational:
  - The winner's *_addr_ok is 1 in the same cycle.
  - mem_en = 1; mem_addr, mem_we and mem_wdata are muxed from the winner.
  - mem_we = data_wstrb if DATA and data_wr, else 0.
  - The loser's addr_ok is 0; the loser must keep req and its fields stable.
- On grant: state becomes BUSY, owner is latched, cnt = RD_LATENCY.
- BUSY: cnt decrements each cycle. In the cycle cnt==1:
  - The owner's *_data_ok = 1.
  - Owner rdata = mem_rdata for loads/fetches; 0 for stores.
  - Non-owner rdata = 0.
  - If no new grant occurs, state becomes IDLE next cycle.
- *_data_ok is a single-cycle pulse per accepted request, in request order. The arbiter issues no further grant to a side until that side's pending data_ok pulse has been delivered.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when inst_req is high in a grant opportunity and DATA wins.
  - Clears when INST is granted or inst_req is low.
- Reset mid-transaction: the in-flight access is abandoned. No data_ok is emitted after reset releases, and no mem_en is issued while resetn==0.
- Requests while not at a grant opportunity are ignored: addr_ok stays 0 and req must remain held.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - The starve counter is removed.
  - When both requesters contend, priority alternates: the side that did not win the last contended grant wins.
  - After reset, DATA is preferred first.
  - Uncontended grants do not change priority.
- Undefined: fixed data priority with the STARVE_MAX counter, as above.

Test Plan:
- Single fetch, RD_LATENCY=1: inst_req, addr 0x1c000000 at cycle 0, mem returns 0x02800421. Required: inst_addr_ok at cycle 0, mem_en=1, mem_we=0; inst_data_ok with inst_rdata=0x02800421 at cycle 1.
- Collision: inst_req and data_req (load, addr 0x00001000) both at cycle 0. Required: data_addr_ok at cycle 0; inst_addr_ok at cycle 1; data_data_ok at 1; inst_data_ok at 2.
- Store: data_wr=1, wstrb=4'b0011, addr 0x00000010, wdata 0xdeadbeef. Required: mem_we=4'b0011, mem_wdata=0xdeadbeef; data_data_ok next cycle with data_rdata=0.
- Starvation, STARVE_MAX=4: data_req and inst_req held continuously. Required: 4 data grants then 1 inst grant, repeating; with ARB_ROUND_ROBIN_EN the grants alternate D,I,D,I.
- RD_LATENCY=3: back-to-back inst fetches. Required: grants at cycles 0, 3, 6; data_ok pulses at 3, 6, 9.
- Reset mid-op: grant at cycle 0 with RD_LATENCY=3, resetn=0 at cycle 1 for one cycle. Required: no data_ok pulse at cycle 3; all outputs 0 during reset.

Source files
------------

// File: rtl/sram_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// sram_arbiter_2to1
//
// Purpose:
//   Shares one synchronous single-port SRAM between the CPU instruction-fetch
//   side and the data-access side. Each side uses a req / addr_ok / data_ok
//   handshake. At most one access is in flight on the memory port. A new grant
//   may be issued in the same cycle the previous access returns its data
//   (back-to-back issue), so a fully loaded port runs one access every
//   RD_LATENCY cycles.
//
//   Arbitration (default build): the data side has fixed priority. The inst
//   side is protected by a starve counter. Once inst has lost STARVE_MAX
//   consecutive contended grant opportunities, it wins the next one.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, the starve counter is removed. Contended
//                        grants alternate between the two sides, with DATA
//                        preferred first after reset. Uncontended grants do not
//                        move the priority.
//
// Parameters:
//   ADDR_W      address width on all ports
//   DATA_W      data width (byte strobes are DATA_W/8 wide)
//   RD_LATENCY  cycles from mem_en to valid mem_rdata (>= 1)
//   STARVE_MAX  lost arbitrations after which a waiting inst request wins (>= 1)
//
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   inst_req/inst_addr        fetch request; held until inst_addr_ok
//   inst_addr_ok              fetch accepted this cycle
//   inst_data_ok/inst_rdata   fetch data valid this cycle
//   data_req/wr/wstrb/addr/wdata  data request; held until data_addr_ok
//   data_addr_ok              data request accepted this cycle
//   data_data_ok/data_rdata   load data valid / store complete (rdata 0 for stores)
//   mem_en/we/addr/wdata      SRAM command, driven combinationally on a grant
//   mem_rdata                 SRAM read data, valid RD_LATENCY cycles after mem_en
// -----------------------------------------------------------------------------
module sram_arbiter_2to1 #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } owner_t;

    state_t             r_state;
    state_t             w_state_next;
    owner_t             r_owner;
    owner_t             w_owner_next;
    logic               r_store;
    logic               w_store_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

`ifdef ARB_ROUND_ROBIN_EN
    // 1: inst wins the next contended grant, 0: data wins it
    logic               r_prefer_inst;
    logic               w_prefer_inst_next;
`else
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    logic [STV_W-1:0]   r_starve;
    logic [STV_W-1:0]   w_starve_next;
`endif

    logic w_done;
    logic w_opp;
    logic w_grant_inst;
    logic w_grant_data;

    // The in-flight access returns its data in the cycle cnt reaches 1. That
    // cycle is also a grant opportunity, so the next access can be issued
    // without an idle bubble.
    assign w_done = (r_state == S_BUSY) && (r_cnt == CNT_W'(1));
    assign w_opp  = (r_state == S_IDLE) || w_done;

    // Arbitration. Everything is qualified by resetn so nothing reaches the
    // memory or the requesters while reset is asserted.
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (resetn && w_opp) begin
            if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (r_prefer_inst) begin
                    w_grant_inst = 1'b1;
                end else begin
                    w_grant_data = 1'b1;
                end
`else
                if (r_starve == STV_W'(STARVE_MAX)) begin
                    w_grant_inst = 1'b1;
                end else begin
                    w_grant_data = 1'b1;
                end
`endif
            end else if (data_req) begin
                w_grant_data = 1'b1;
            end else if (inst_req) begin
                w_grant_inst = 1'b1;
            end
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_store_next = r_store;
        w_cnt_next   = r_cnt;
`ifdef ARB_ROUND_ROBIN_EN
        w_prefer_inst_next = r_prefer_inst;
`else
        w_starve_next = r_starve;
`endif
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        mem_en       = 1'b0;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        // Completion of the access in flight
        if (resetn && w_done) begin
            if (r_owner == OWN_INST) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_rdata;
            end else if (r_owner == OWN_DATA) begin
                data_data_ok = 1'b1;
                data_rdata   = r_store ? '0 : mem_rdata;
            end
        end

        // Memory command from the winner
        if (w_grant_inst) begin
            inst_addr_ok = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = inst_addr;
        end else if (w_grant_data) begin
            data_addr_ok = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = data_addr;
            mem_wdata    = data_wdata;
            mem_we       = data_wr ? data_wstrb : '0;
        end

        // Sequencing
        if (w_grant_inst || w_grant_data) begin
            w_state_next = S_BUSY;
            w_owner_next = w_grant_inst ? OWN_INST : OWN_DATA;
            w_store_next = w_grant_data && data_wr;
            w_cnt_next   = CNT_W'(RD_LATENCY);
        end else if (r_state == S_BUSY) begin
            if (w_done) begin
                w_state_next = S_IDLE;
                w_owner_next = OWN_NONE;
                w_store_next = 1'b0;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end

`ifdef ARB_ROUND_ROBIN_EN
        // Only contended grants move the priority
        if (w_grant_inst && data_req) begin
            w_prefer_inst_next = 1'b0;
        end else if (w_grant_data && inst_req) begin
            w_prefer_inst_next = 1'b1;
        end
`else
        // A data grant while inst is requesting can only happen at a grant
        // opportunity, so it counts as one lost arbitration for inst.
        if (!inst_req || w_grant_inst) begin
            w_starve_next = '0;
        end else if (w_grant_data && (r_starve != STV_W'(STARVE_MAX))) begin
            w_starve_next = r_starve + STV_W'(1);
        end
`endif
    end

    // State registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
            r_store <= 1'b0;
            r_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_prefer_inst <= 1'b0;
`else
            r_starve <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_store <= w_store_next;
            r_cnt   <= w_cnt_next;
`ifdef ARB_ROUND_ROBIN_EN
            r_prefer_inst <= w_prefer_inst_next;
`else
            r_starve <= w_starve_next;
`endif
        end
    end

endmodule
